pc_fetch_unit: RTL and testbench

// Program-counter and instruction-fetch stage, directly upstream of the control unit.

---
 rtl/pc_fetch_unit.sv | 162 ++++++++++++++++
 tb/tb_pc_fetch_unit.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit
//   Program-counter and instruction-fetch stage feeding decode/control.
//   Fetches the word at PC over a req/ack handshake, holds it until the
//   execute stage retires it, then advances PC to PC+4 or to the control
//   unit's branch/jump target. A fetch that goes unanswered for TIMEOUT_CYC
//   cycles is dropped for one cycle and reissued. A misaligned next PC halts
//   the stage until reset.
//
// Parameters
//   RESET_VECTOR  word-aligned PC loaded on reset
//   TIMEOUT_CYC   FETCH cycles without imem_ack before the request is reissued (>=2)
//
// Ports
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset
//   imem_req       registered fetch request
//   imem_addr      fetch address (the PC register)
//   imem_ack       response valid; imem_rdata captured on the same edge
//   imem_rdata     instruction word
//   Instr          latched instruction for decode/control
//   instr_valid    Instr holds a live instruction
//   retire         execute done with Instr; PCSrc/PCTarget valid this cycle
//   PCSrc          1 = next PC is PCTarget, 0 = PC+4
//   PCTarget       branch/jump target
//   PC             current program counter
//   PCPlus4        PC+4, combinational, wraps at 2^32
//   fetch_timeout  one-cycle pulse per dropped request
//   misalign       sticky flag: a retire selected a next PC with [1:0]!=0

module pc_fetch_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int unsigned TIMEOUT_CYC  = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] Instr,
    output logic        instr_valid,
    input  logic        retire,
    input  logic        PCSrc,
    input  logic [31:0] PCTarget,
    output logic [31:0] PC,
    output logic [31:0] PCPlus4,
    output logic        fetch_timeout,
    output logic        misalign
);

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam int unsigned TW = $clog2(TIMEOUT_CYC);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        BOOT,
        FETCH,
        RETRY,
        HOLD,
        HALT
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [TW-1:0] timer;
    logic [TW-1:0] timer_next;
    logic [31:0]   pc_next;
    logic [31:0]   pc_sel;
    logic [31:0]   instr_next;
    logic          valid_next;
    logic          misalign_next;
    logic          sel_aligned;

    assign PCPlus4     = PC + 32'd4;
    assign imem_addr   = PC;
    assign pc_sel      = PCSrc ? PCTarget : PCPlus4;
    assign sel_aligned = (pc_sel[1:0] == 2'b00);

    // State register plus all registered outputs. imem_req and fetch_timeout
    // are decoded from the next state so they line up with the state they
    // belong to without an extra cycle of lag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= BOOT;
            timer         <= '0;
            PC            <= RESET_VECTOR;
            Instr         <= NOP;
            instr_valid   <= 1'b0;
            misalign      <= 1'b0;
            imem_req      <= 1'b0;
            fetch_timeout <= 1'b0;
        end else begin
            state         <= state_next;
            timer         <= timer_next;
            PC            <= pc_next;
            Instr         <= instr_next;
            instr_valid   <= valid_next;
            misalign      <= misalign_next;
            imem_req      <= (state_next == FETCH);
            fetch_timeout <= (state_next == RETRY);
        end
    end

    // Next-state logic. An ack on the last timer cycle takes priority over
    // the timeout.
    always_comb begin
        state_next = state;
        unique case (state)
            BOOT:  state_next = FETCH;
            FETCH: begin
                if (imem_ack) begin
                    state_next = HOLD;
                end else if (timer == TIMER_LAST) begin
                    state_next = RETRY;
                end
            end
            RETRY: state_next = FETCH;
            HOLD: begin
                if (retire) begin
                    state_next = sel_aligned ? FETCH : HALT;
                end
            end
            HALT:    state_next = HALT;
            default: state_next = BOOT;
        endcase
    end

    // Output / datapath next values.
    always_comb begin
        timer_next    = timer;
        pc_next       = PC;
        instr_next    = Instr;
        valid_next    = instr_valid;
        misalign_next = misalign;
        unique case (state)
            FETCH: begin
                if (imem_ack) begin
                    instr_next = imem_rdata;
                    valid_next = 1'b1;
                    timer_next = '0;
                end else if (timer == TIMER_LAST) begin
                    timer_next = '0;
                end else begin
                    timer_next = timer + TW'(1);
                end
            end
            HOLD: begin
                if (retire) begin
                    valid_next = 1'b0;
                    if (sel_aligned) begin
                        pc_next = pc_sel;
                    end else begin
                        misalign_next = 1'b1;
                    end
                end
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit
//   Directed bench for pc_fetch_unit with RESET_VECTOR=0x100, TIMEOUT_CYC=16.
//   Inputs are driven 1 time unit after each rising edge and outputs are
//   sampled at the same point, so every check sees the state the preceding
//   edge produced.

module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [31:0] Instr;
    logic        instr_valid;
    logic        retire = 1'b0;
    logic        PCSrc = 1'b0;
    logic [31:0] PCTarget = '0;
    logic [31:0] PC;
    logic [31:0] PCPlus4;
    logic        fetch_timeout;
    logic        misalign;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    pc_fetch_unit #(
        .RESET_VECTOR(32'h0000_0100),
        .TIMEOUT_CYC (16)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .Instr        (Instr),
        .instr_valid  (instr_valid),
        .retire       (retire),
        .PCSrc        (PCSrc),
        .PCTarget     (PCTarget),
        .PC           (PC),
        .PCPlus4      (PCPlus4),
        .fetch_timeout(fetch_timeout),
        .misalign     (misalign)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Raise ack for exactly one edge with the given instruction word.
    task automatic ack_now(input logic [31:0] data);
        imem_ack   = 1'b1;
        imem_rdata = data;
        step();
        imem_ack   = 1'b0;
    endtask

    task automatic do_retire(input logic src, input logic [31:0] tgt);
        retire   = 1'b1;
        PCSrc    = src;
        PCTarget = tgt;
        step();
        retire   = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        step();
        step();
        check("rst_req", {31'b0, imem_req}, 32'd0);
        check("rst_valid", {31'b0, instr_valid}, 32'd0);
        check("rst_pc", PC, 32'h100);
        check("rst_instr", Instr, 32'h13);
        check("rst_misalign", {31'b0, misalign}, 32'd0);
        check("rst_timeout", {31'b0, fetch_timeout}, 32'd0);
        check("rst_pcplus4", PCPlus4, 32'h104);

        // 1: one idle BOOT cycle, then fetch at reset vector
        rst_n = 1'b1;
        check("boot_req_idle", {31'b0, imem_req}, 32'd0);
        step();
        check("fetch1_req", {31'b0, imem_req}, 32'd1);
        check("fetch1_addr", imem_addr, 32'h100);

        // 2: ack in third FETCH cycle
        step();
        check("fetch2_req", {31'b0, imem_req}, 32'd1);
        check("fetch2_valid", {31'b0, instr_valid}, 32'd0);
        step();
        ack_now(32'h0050_0093);
        check("hold_instr", Instr, 32'h0050_0093);
        check("hold_valid", {31'b0, instr_valid}, 32'd1);
        check("hold_req", {31'b0, imem_req}, 32'd0);
        do_retire(1'b0, 32'h0);
        check("seq_pc", PC, 32'h104);
        check("seq_addr", imem_addr, 32'h104);
        check("seq_req", {31'b0, imem_req}, 32'd1);
        check("seq_valid", {31'b0, instr_valid}, 32'd0);

        // Minimum latency: ack in first FETCH cycle
        ack_now(32'h00A0_0113);
        check("minlat_instr", Instr, 32'h00A0_0113);
        check("minlat_valid", {31'b0, instr_valid}, 32'd1);

        // ack ignored in HOLD
        ack_now(32'hDEAD_BEEF);
        check("hold_ack_ign", Instr, 32'h00A0_0113);
        check("hold_ack_valid", {31'b0, instr_valid}, 32'd1);

        // 3a: taken branch to 0x200
        do_retire(1'b1, 32'h200);
        check("br_addr", imem_addr, 32'h200);
        check("br_req", {31'b0, imem_req}, 32'd1);

        // retire ignored in FETCH (this is FETCH cycle 1, no ack)
        do_retire(1'b1, 32'h300);
        check("fetch_ret_ign", PC, 32'h200);

        // 4: no ack for 16 FETCH cycles; currently in cycle 2
        for (int i = 3; i <= 16; i++) begin
            step();
        end
        check("to_c16_req", {31'b0, imem_req}, 32'd1);
        check("to_c16_pulse", {31'b0, fetch_timeout}, 32'd0);
        step();
        check("to_pulse", {31'b0, fetch_timeout}, 32'd1);
        check("to_req_low", {31'b0, imem_req}, 32'd0);
        step();
        check("to_pulse_end", {31'b0, fetch_timeout}, 32'd0);
        check("reissue_req", {31'b0, imem_req}, 32'd1);
        check("reissue_addr", imem_addr, 32'h200);

        // 4 variant: ack on the 16th FETCH cycle wins over the timeout
        repeat (15) step();
        ack_now(32'h0140_0193);
        check("ack16_pulse", {31'b0, fetch_timeout}, 32'd0);
        check("ack16_valid", {31'b0, instr_valid}, 32'd1);
        check("ack16_instr", Instr, 32'h0140_0193);

        // 5: PC+4 wraps
        do_retire(1'b1, 32'hFFFF_FFFC);
        check("wrap_pc", PC, 32'hFFFF_FFFC);
        check("wrap_pcplus4", PCPlus4, 32'h0);
        ack_now(32'h13);
        do_retire(1'b0, 32'h0);
        check("wrap_pc0", PC, 32'h0);
        check("wrap_addr0", imem_addr, 32'h0);
        check("wrap_pcplus4_4", PCPlus4, 32'h4);
        check("wrap_misalign", {31'b0, misalign}, 32'd0);

        // 3b: misaligned target halts
        ack_now(32'h13);
        do_retire(1'b1, 32'h202);
        check("mis_flag", {31'b0, misalign}, 32'd1);
        check("mis_pc", PC, 32'h0);
        check("mis_valid", {31'b0, instr_valid}, 32'd0);
        check("mis_req", {31'b0, imem_req}, 32'd0);
        imem_ack = 1'b1;
        retire   = 1'b1;
        repeat (4) step();
        imem_ack = 1'b0;
        retire   = 1'b0;
        check("halt_req", {31'b0, imem_req}, 32'd0);
        check("halt_sticky", {31'b0, misalign}, 32'd1);
        check("halt_pc", PC, 32'h0);

        // 6: reset out of HALT, then mid-FETCH
        rst_n = 1'b0;
        #1;
        check("halt_rst_mis", {31'b0, misalign}, 32'd0);
        check("halt_rst_pc", PC, 32'h100);
        step();
        rst_n = 1'b1;
        step();
        check("re_fetch_req", {31'b0, imem_req}, 32'd1);
        step();
        #2;
        rst_n = 1'b0;
        #1;
        check("midf_req", {31'b0, imem_req}, 32'd0);
        check("midf_valid", {31'b0, instr_valid}, 32'd0);
        check("midf_pc", PC, 32'h100);
        step();
        rst_n = 1'b1;
        step();
        ack_now(32'h0050_0093);
        do_retire(1'b0, 32'h0);
        ack_now(32'h0020_0213);
        check("pre_rst_pc", PC, 32'h104);
        check("pre_rst_valid", {31'b0, instr_valid}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("midh_req", {31'b0, imem_req}, 32'd0);
        check("midh_valid", {31'b0, instr_valid}, 32'd0);
        check("midh_pc", PC, 32'h100);
        check("midh_instr", Instr, 32'h13);
        step();
        rst_n = 1'b1;
        step();
        check("post_req", {31'b0, imem_req}, 32'd1);
        check("post_addr", imem_addr, 32'h100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
